chess_board_renderer: RTL and testbench
=======================================

// Module: chess_board_renderer
// PURPOSE
//  Pixel-pipeline stage feeding the sprite ROM and consuming its 4-bit colour index.
//  Maps VGA DrawX/DrawY to a board square and holds the 64-entry board state.
//  Issues img_addr/pixel_addr to the sprite ROM, which has 1-cycle registered read.
//  Resolves transparency (index 0), square shading and cursor highlight into 4:4:4 RGB for the VGA DAC.
// PARAMETERS
//  BOARD_X0   80   left edge of 480x480 board, pixels
//  BOARD_Y0   0    top edge of board, pixels
//  SQ_PIX     60   square edge, pixels; fixed to match sprite size
// PORTS
//  CLK         in   1   pixel clock; single clock domain
//  Reset       in   1   synchronous, active-high
//  DrawX       in   10  current pixel column
//  DrawY       in   10  current pixel row
//  blank       in   1   1 = visible region, 0 = blanking
//  bd_we       in   1   board write strobe
//  bd_addr     in   6   board write square (0 = top-left, row*8+col)
//  bd_data     in   4   piece code: {type[2:0], white}; 12 = empty
//  cursor_en   in   1   enable cursor highlight
//  cursor_sq   in   6   highlighted square
//  img_addr    out  4   to sprite ROM: piece code of current square
//  pixel_addr  out  12  to sprite ROM: py*60+px, 0..3599
//  sprite_data in   4   from sprite ROM: colour index, valid 1 cycle after address
//  Red/Green/Blue out 4 each  pixel colour
//  blank_out   out  1   blank delayed to align with RGB
// BEHAVIOUR
//  Pipeline, 3 cycles DrawX/DrawY -> RGB, fully pipelined, one pixel per cycle:
//   S1 (reg):
//    - in_board = DrawX in [X0, X0+480) && DrawY in [Y0, Y0+480).
//    - col/row by 7-comparator chain (no divider); px = dx-60*col, py likewise.
//    - img_addr <= in_board ? board[row*8+col] : 12.
//    - pixel_addr <= in_board ? py*60+px : 0.
//    - Also register parity (row+col)[0], cursor hit, in_board, blank.
//   S2 (reg): sprite ROM returns data; register its side-band from S1.
//   S3 (reg):
//    - !blank -> RGB 0.
//    - !in_board -> BG_COLOUR.
//    - sprite_data != 0 -> PALETTE[sprite_data].
//    - else cursor hit -> CURSOR_COLOUR.
//    - else parity 0 -> LIGHT_SQ, parity 1 -> DARK_SQ.
//  Arithmetic:
//   - dx = DrawX - X0, 10-bit, evaluated only when in_board.
//   - pixel_addr max 59*60+59 = 3599; never exceeds.
//  Board memory: 64 x 4 regs, write-after-read.
//   - Write lands at clock edge; visible to S1 reads the next cycle.
//   - Same-cycle write and read of one square returns old value.
//   - bd_data codes 13..15 stored as-is (undefined sprite); writer must not issue them.
//  Boundaries:
//   - DrawX = X0+479 -> col 7, px 59.
//   - DrawX = X0+480 -> outside board.
//   - Square edge DrawX = X0+60 -> col 1, px 0.
//  Reset, synchronous, any cycle including mid-frame:
//   - board <= standard opening: sq 0..7 = 6,2,4,8,10,4,2,6; sq 8..15 = 0.
//   - sq 16..47 = 12; sq 48..55 = 1; sq 56..63 = 7,3,5,9,11,5,3,7.
//   - img_addr <= 12, pixel_addr <= 0, all side-band regs <= 0.
//   - Red/Green/Blue <= 0, blank_out <= 0.
//   - Output is valid again 3 cycles after Reset deasserts.
//  Reset has priority over a concurrent bd_we.
// STRUCTURE
//  Package chess_pkg:
//   - piece code enum: PAWN..KING, EMPTY=12.
//   - 16-entry PALETTE (12-bit RGB).
//   - BG_COLOUR, LIGHT_SQ, DARK_SQ, CURSOR_COLOUR constants.
//   - INIT_BOARD[64] array.
//  One sub-module board_coord_map: DrawX/DrawY -> in_board, row, col, px, py (combinational, reused by S1).
// TESTING
//  1. Reset, then DrawX=110, DrawY=30:
//     - img_addr=6, pixel_addr=1830 after 1 cycle.
//     - sprite_data=5 -> RGB=PALETTE[5] after 3 cycles.
//  2. DrawX=80+60*2+5, DrawY=60*3+7, sprite_data=0:
//     - sq 26, img_addr=12, pixel_addr=425.
//     - RGB=DARK_SQ, since parity (3+2) is odd.
//  3. bd_we, bd_addr=26, bd_data=1 while S1 reads sq 26:
//     - old code 12 that cycle; 1 on the next read of sq 26.
//  4. DrawX=10 and DrawX=560, DrawY=100 -> img_addr=12, RGB=BG_COLOUR.
//     DrawX=559 -> col 7, px 59.
//  5. cursor_en=1, cursor_sq=0, sprite_data=0 on sq 0 -> CURSOR_COLOUR.
//     Same with sprite_data=3 -> PALETTE[3].
//  6. blank=0 -> RGB 0.
//     Reset pulsed mid-stream after writes -> outputs 0, board restored to opening position.

Source files
------------

// File: rtl/chess_pkg.sv
// Shared types and constants for the chess board renderer: piece codes, palette,
// square shading colours and the opening position loaded on reset.
package chess_pkg;

    // Piece code is {type[2:0], white}; only the black codes are enumerated here.
    typedef enum logic [3:0] {
        PAWN   = 4'd0,
        KNIGHT = 4'd2,
        BISHOP = 4'd4,
        ROOK   = 4'd6,
        QUEEN  = 4'd8,
        KING   = 4'd10,
        EMPTY  = 4'd12
    } piece_e;

    localparam logic [11:0] PALETTE [16] = '{
        12'h000, 12'hFFF, 12'h111, 12'hCCC, 12'h888, 12'hF00, 12'h0F0, 12'h00F,
        12'hFF0, 12'h0FF, 12'hF0F, 12'h840, 12'h48C, 12'hC84, 12'h555, 12'hAAA
    };

    localparam logic [11:0] BG_COLOUR     = 12'h222;
    localparam logic [11:0] LIGHT_SQ      = 12'hEDB;
    localparam logic [11:0] DARK_SQ       = 12'h853;
    localparam logic [11:0] CURSOR_COLOUR = 12'h4F4;

    localparam logic [3:0] INIT_BOARD [64] = '{
        4'd6,  4'd2,  4'd4,  4'd8,  4'd10, 4'd4,  4'd2,  4'd6,
        4'd0,  4'd0,  4'd0,  4'd0,  4'd0,  4'd0,  4'd0,  4'd0,
        4'd12, 4'd12, 4'd12, 4'd12, 4'd12, 4'd12, 4'd12, 4'd12,
        4'd12, 4'd12, 4'd12, 4'd12, 4'd12, 4'd12, 4'd12, 4'd12,
        4'd12, 4'd12, 4'd12, 4'd12, 4'd12, 4'd12, 4'd12, 4'd12,
        4'd12, 4'd12, 4'd12, 4'd12, 4'd12, 4'd12, 4'd12, 4'd12,
        4'd1,  4'd1,  4'd1,  4'd1,  4'd1,  4'd1,  4'd1,  4'd1,
        4'd7,  4'd3,  4'd5,  4'd9,  4'd11, 4'd5,  4'd3,  4'd7
    };

endpackage

// File: rtl/board_coord_map.sv
// Combinational map from screen coordinates to board square (row/col) and the
// pixel offset inside that square, using a comparator chain instead of a divider.
module board_coord_map #(
    parameter int unsigned BOARD_X0 = 80,
    parameter int unsigned BOARD_Y0 = 0,
    parameter int unsigned SQ_PIX   = 60
) (
    input  logic [9:0] draw_x_i,
    input  logic [9:0] draw_y_i,
    output logic       in_board_o,
    output logic [2:0] row_o,
    output logic [2:0] col_o,
    output logic [5:0] px_o,
    output logic [5:0] py_o
);

    localparam logic [9:0] X0   = 10'(BOARD_X0);
    localparam logic [9:0] Y0   = 10'(BOARD_Y0);
    localparam logic [9:0] Span = 10'(8 * SQ_PIX);

    logic [9:0] dx, dy, x_base, y_base;

    always_comb begin
        // Coordinates left of/above the board wrap to large values and fail the span test.
        dx         = draw_x_i - X0;
        dy         = draw_y_i - Y0;
        in_board_o = (dx < Span) && (dy < Span);
        col_o      = '0;
        row_o      = '0;
        x_base     = '0;
        y_base     = '0;
        for (int k = 1; k < 8; k++) begin
            if (dx >= 10'(k * SQ_PIX)) begin
                col_o  = 3'(k);
                x_base = 10'(k * SQ_PIX);
            end
            if (dy >= 10'(k * SQ_PIX)) begin
                row_o  = 3'(k);
                y_base = 10'(k * SQ_PIX);
            end
        end
        px_o = 6'(dx - x_base);
        py_o = 6'(dy - y_base);
    end

endmodule

// File: rtl/chess_board_renderer.sv
// Three-stage pixel pipeline: square lookup and sprite address, sprite ROM wait,
// then colour resolution (transparency, cursor, square shading) into 4:4:4 RGB.
module chess_board_renderer
    import chess_pkg::*;
#(
    parameter int unsigned BOARD_X0 = 80,
    parameter int unsigned BOARD_Y0 = 0,
    parameter int unsigned SQ_PIX   = 60
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        blank,
    input  logic        bd_we,
    input  logic [5:0]  bd_addr,
    input  logic [3:0]  bd_data,
    input  logic        cursor_en,
    input  logic [5:0]  cursor_sq,
    output logic [3:0]  img_addr,
    output logic [11:0] pixel_addr,
    input  logic [3:0]  sprite_data,
    output logic [3:0]  Red,
    output logic [3:0]  Green,
    output logic [3:0]  Blue,
    output logic        blank_out
);

    logic [3:0]  board_q [64];

    logic        in_board;
    logic [2:0]  row, col;
    logic [5:0]  px, py, sq;

    logic [3:0]  img_addr_d, img_addr_q;
    logic [11:0] pixel_addr_d, pixel_addr_q;
    logic        parity_d, parity1_q, parity2_q;
    logic        cur_hit_d, cur1_q, cur2_q;
    logic        inb1_q, inb2_q;
    logic        blank1_q, blank2_q;
    logic [11:0] rgb_d, rgb_q;
    logic        blank_out_q;

    board_coord_map #(
        .BOARD_X0 (BOARD_X0),
        .BOARD_Y0 (BOARD_Y0),
        .SQ_PIX   (SQ_PIX)
    ) u_coord (
        .draw_x_i   (DrawX),
        .draw_y_i   (DrawY),
        .in_board_o (in_board),
        .row_o      (row),
        .col_o      (col),
        .px_o       (px),
        .py_o       (py)
    );

    // Write-after-read: a same-cycle S1 read of the written square sees the old code.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            board_q <= INIT_BOARD;
        end else if (bd_we) begin
            board_q[bd_addr] <= bd_data;
        end
    end

    always_comb begin
        sq           = {row, col};
        img_addr_d   = in_board ? board_q[sq] : EMPTY;
        pixel_addr_d = in_board ? (12'(py) * 12'(SQ_PIX) + 12'(px)) : '0;
        parity_d     = row[0] ^ col[0];
        cur_hit_d    = cursor_en && in_board && (cursor_sq == sq);
    end

    always_comb begin
        rgb_d = '0;
        if (!blank2_q) begin
            rgb_d = '0;
        end else if (!inb2_q) begin
            rgb_d = BG_COLOUR;
        end else if (sprite_data != 4'd0) begin
            rgb_d = PALETTE[sprite_data];
        end else if (cur2_q) begin
            rgb_d = CURSOR_COLOUR;
        end else begin
            rgb_d = parity2_q ? DARK_SQ : LIGHT_SQ;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            img_addr_q   <= EMPTY;
            pixel_addr_q <= '0;
            parity1_q    <= 1'b0;
            cur1_q       <= 1'b0;
            inb1_q       <= 1'b0;
            blank1_q     <= 1'b0;
            parity2_q    <= 1'b0;
            cur2_q       <= 1'b0;
            inb2_q       <= 1'b0;
            blank2_q     <= 1'b0;
            rgb_q        <= '0;
            blank_out_q  <= 1'b0;
        end else begin
            img_addr_q   <= img_addr_d;
            pixel_addr_q <= pixel_addr_d;
            parity1_q    <= parity_d;
            cur1_q       <= cur_hit_d;
            inb1_q       <= in_board;
            blank1_q     <= blank;
            parity2_q    <= parity1_q;
            cur2_q       <= cur1_q;
            inb2_q       <= inb1_q;
            blank2_q     <= blank1_q;
            rgb_q        <= rgb_d;
            blank_out_q  <= blank2_q;
        end
    end

    assign img_addr   = img_addr_q;
    assign pixel_addr = pixel_addr_q;
    assign Red        = rgb_q[11:8];
    assign Green      = rgb_q[7:4];
    assign Blue       = rgb_q[3:0];
    assign blank_out  = blank_out_q;

endmodule

// File: tb/tb_chess_board_renderer.sv
// Randomised bench for chess_board_renderer against a per-pixel reference model
// with a registered sprite ROM stand-in.
module tb_chess_board_renderer;
    import chess_pkg::*;

    logic        CLK = 1'b0;
    logic        Reset, blank, bd_we, cursor_en;
    logic [9:0]  DrawX, DrawY;
    logic [5:0]  bd_addr, cursor_sq;
    logic [3:0]  bd_data, img_addr, sprite_data, Red, Green, Blue;
    logic [11:0] pixel_addr;
    logic        blank_out;

    int checks = 0;
    int failures = 0;
    int rom_force = -1;

    always #5 CLK = ~CLK;

    chess_board_renderer dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .blank       (blank),
        .bd_we       (bd_we),
        .bd_addr     (bd_addr),
        .bd_data     (bd_data),
        .cursor_en   (cursor_en),
        .cursor_sq   (cursor_sq),
        .img_addr    (img_addr),
        .pixel_addr  (pixel_addr),
        .sprite_data (sprite_data),
        .Red         (Red),
        .Green       (Green),
        .Blue        (Blue),
        .blank_out   (blank_out)
    );

    // Sprite ROM: forced colour index when rom_force >= 0, else an address hash.
    function automatic logic [3:0] rom_fn(input logic [3:0] img, input logic [11:0] pix,
                                          input int frc);
        logic [11:0] h;
        if (frc >= 0) return 4'(frc);
        h = pix ^ {img, 8'h00} ^ (pix >> 5) ^ 12'(img * 3);
        return h[3:0];
    endfunction

    always @(posedge CLK) sprite_data <= rom_fn(img_addr, pixel_addr, rom_force);

    function automatic logic [3:0] opening(input int sq);
        int back [8];
        back = '{6, 2, 4, 8, 10, 4, 2, 6};
        if (sq < 8) return 4'(back[sq]);
        if (sq < 16) return 4'd0;
        if (sq < 48) return 4'd12;
        if (sq < 56) return 4'd1;
        return 4'(back[sq - 56] + 1);
    endfunction

    typedef struct {
        logic [3:0]  img;
        logic [11:0] pix;
        bit          inb, par, cur, blk, rst;
        int          frc;
    } ent_t;

    ent_t        e0, e1, e2;
    logic [3:0]  mboard [64];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int dx, input int dy, input bit bl, input bit we, input int wa,
                        input int wd, input bit ce, input int cs, input bit rst, input int frc);
        ent_t        e;
        int          row, col;
        logic [3:0]  spr;
        logic [11:0] exp_rgb;
        bit          exp_bo;
        DrawX = 10'(dx); DrawY = 10'(dy); blank = bl;
        bd_we = we; bd_addr = 6'(wa); bd_data = 4'(wd);
        cursor_en = ce; cursor_sq = 6'(cs); Reset = rst; rom_force = frc;
        e.rst = rst; e.frc = frc;
        e.inb = 0; e.par = 0; e.cur = 0; e.blk = 0; e.img = 4'd12; e.pix = 12'd0;
        if (!rst) begin
            e.blk = bl;
            if (dx >= 80 && dx < 560 && dy < 480) begin
                col   = (dx - 80) / 60;
                row   = dy / 60;
                e.inb = 1;
                e.img = mboard[row * 8 + col];
                e.pix = 12'((dy % 60) * 60 + (dx - 80) % 60);
                e.par = ((row + col) % 2) == 1;
                e.cur = ce && (cs == row * 8 + col);
            end
        end
        @(posedge CLK);
        if (rst) for (int i = 0; i < 64; i++) mboard[i] = opening(i);
        else if (we) mboard[wa] = 4'(wd);
        e2 = e1; e1 = e0; e0 = e;
        #1;
        check_eq("img_addr", 32'(img_addr), 32'(e0.img));
        check_eq("pixel_addr", 32'(pixel_addr), 32'(e0.pix));
        exp_rgb = 12'h000;
        exp_bo  = 0;
        if (!(e0.rst || e1.rst || e2.rst)) begin
            exp_bo = e2.blk;
            spr    = rom_fn(e2.img, e2.pix, e1.frc);
            if (!e2.blk) exp_rgb = 12'h000;
            else if (!e2.inb) exp_rgb = BG_COLOUR;
            else if (spr != 0) exp_rgb = PALETTE[spr];
            else if (e2.cur) exp_rgb = CURSOR_COLOUR;
            else exp_rgb = e2.par ? DARK_SQ : LIGHT_SQ;
        end
        check_eq("rgb", 32'({Red, Green, Blue}), 32'(exp_rgb));
        check_eq("blank_out", 32'(blank_out), 32'(exp_bo));
    endtask

    task automatic pix(input int dx, input int dy, input int frc);
        step(dx, dy, 1, 0, 0, 0, 0, 0, 0, frc);
    endtask

    initial begin
        e0.rst = 1; e1.rst = 1; e2.rst = 1;
        for (int i = 0; i < 64; i++) mboard[i] = opening(i);
        for (int i = 0; i < 3; i++) step(110, 30, 1, 0, 0, 0, 0, 0, 1, 0);
        check_eq("rst_img", 32'(img_addr), 32'd12);
        check_eq("rst_rgb", 32'({Red, Green, Blue}), 32'd0);
        check_eq("rst_blank_out", 32'(blank_out), 32'd0);

        // Opening rook square, sprite index 5.
        pix(110, 30, 5);
        check_eq("t1_img", 32'(img_addr), 32'd6);
        check_eq("t1_pix", 32'(pixel_addr), 32'd1830);
        pix(110, 30, 5);
        pix(110, 30, 5);
        check_eq("t1_rgb", 32'({Red, Green, Blue}), 32'(PALETTE[5]));

        // Empty dark square 26.
        pix(205, 187, 0);
        check_eq("t2_img", 32'(img_addr), 32'd12);
        check_eq("t2_pix", 32'(pixel_addr), 32'd425);
        pix(205, 187, 0);
        pix(205, 187, 0);
        check_eq("t2_rgb", 32'({Red, Green, Blue}), 32'(DARK_SQ));

        // Write to the square being read.
        step(205, 187, 1, 1, 26, 1, 0, 0, 0, 0);
        check_eq("t3_old", 32'(img_addr), 32'd12);
        pix(205, 187, 0);
        check_eq("t3_new", 32'(img_addr), 32'd1);

        // Off-board and right edge.
        pix(10, 100, 0);
        pix(10, 100, 0);
        pix(10, 100, 0);
        check_eq("t4_bg", 32'({Red, Green, Blue}), 32'(BG_COLOUR));
        pix(560, 100, 0);
        check_eq("t4_560_img", 32'(img_addr), 32'd12);
        pix(559, 100, 0);
        check_eq("t4_559_pix", 32'(pixel_addr), 32'd2459);
        pix(140, 100, 0);
        check_eq("t4_140_pix", 32'(pixel_addr), 32'd2400);

        // Cursor over square 0, transparent then opaque sprite.
        for (int i = 0; i < 3; i++) step(100, 10, 1, 0, 0, 0, 1, 0, 0, 0);
        check_eq("t5_cursor", 32'({Red, Green, Blue}), 32'(CURSOR_COLOUR));
        for (int i = 0; i < 3; i++) step(100, 10, 1, 0, 0, 0, 1, 0, 0, 3);
        check_eq("t5_sprite", 32'({Red, Green, Blue}), 32'(PALETTE[3]));

        // Blanking, then writes and a mid-stream reset.
        for (int i = 0; i < 3; i++) step(300, 200, 0, 0, 0, 0, 0, 0, 0, 4);
        check_eq("t6_blank", 32'({Red, Green, Blue}), 32'd0);
        step(300, 200, 1, 1, 0, 12, 0, 0, 0, -1);
        step(300, 200, 1, 1, 40, 9, 0, 0, 0, -1);
        step(300, 200, 1, 1, 5, 3, 0, 0, 1, -1);
        step(300, 200, 1, 0, 0, 0, 0, 0, 1, -1);
        check_eq("t6_rst_rgb", 32'({Red, Green, Blue}), 32'd0);
        pix(205, 187, -1);
        check_eq("t6_sq26", 32'(img_addr), 32'd12);
        pix(80, 0, -1);
        check_eq("t6_sq0", 32'(img_addr), 32'd6);
        pix(380, 10, -1);
        check_eq("t6_sq5", 32'(img_addr), 32'd4);

        for (int n = 0; n < 3000; n++) begin
            int dx, dy, frc;
            case ($urandom_range(0, 3))
                0:       dx = 79 + 60 * $urandom_range(0, 8) + $urandom_range(0, 1);
                default: dx = $urandom_range(0, 639);
            endcase
            dy  = ($urandom_range(0, 3) == 0) ? 59 + 60 * $urandom_range(0, 8) + $urandom_range(0, 1)
                                              : $urandom_range(0, 524);
            frc = ($urandom_range(0, 4) == 0) ? 0 : -1;
            step(dx, dy, $urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 63), $urandom_range(0, 12), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 63), $urandom_range(0, 199) == 0, frc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
